// File: rtl/rr_grant_enc4_pkg.sv
// rr_grant_enc4 shared types and constants.
// Imported by the interface, the picker and the top.
package rr_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } rr_state_t;

endpackage

// File: rtl/rr_grant_enc4_if.sv
// Request/grant bundle between requesters and the encoder.
// slave is the encoder side, master the requester side.
interface rr_grant_enc4_if;
  import rr_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_grant_enc4_pick4.sv
// Round-robin picker: rotate by ptr, fixed-priority
// encode, then rotate the index back.
module rr_pick4
  import rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     enc;

  // rot[i] is the request sitting i places after ptr
  always_comb begin
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[NUM_REQ-1:0];
  end

  // lowest rotated position wins
  always_comb begin
    enc = 2'd0;
    priority case (1'b1)
      rot[0]:  enc = 2'd0;
      rot[1]:  enc = 2'd1;
      rot[2]:  enc = 2'd2;
      rot[3]:  enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  assign idx_o = enc + ptr_i;
  assign any_o = |req_i;

endmodule

// File: rtl/rr_grant_enc4.sv
// Round-robin grant encoder with hold limit and a
// one-cycle bubble between grants.
module rr_grant_enc4
  import rr_pkg::*;
#(
  parameter int HOLD_MAX = 8
)(
  input logic          clk,
  input logic          rst_n,
  rr_grant_enc4_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  rr_state_t        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             rel;

  rr_pick4 u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // next state: grant on any request, release on
  // done, abandon or hold expiry (in that order)
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (pick_any) begin
          idx_d   = pick_idx;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_SAT)
          cnt_d = cnt_q + 1'b1;
        if (bus.done || !bus.req[idx_q]) begin
          rel = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          rel  = 1'b1;
          to_d = 1'b1;
        end
        if (rel) begin
          ptr_d   = idx_q + 1'b1;
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = to_q;

endmodule
